// File: rtl/tcm_lsu_port_if.sv
// Request/response channel and TCM port bundle for tcm_lsu_port.
// slave: the LSU port itself; master: the core/TCM side driving it.
interface tcm_lsu_port_if #(
  parameter int unsigned ADDR_WIDTH = 16
);
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic [31:0]           req_addr_i;
  logic                  req_we_i;
  logic [1:0]            req_size_i;
  logic                  req_unsigned_i;
  logic [31:0]           req_wdata_i;
  logic                  resp_valid_o;
  logic                  resp_ready_i;
  logic [31:0]           resp_rdata_o;
  logic                  resp_err_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [3:0]            mem_wr_o;
  logic [31:0]           mem_wdata_o;
  logic [31:0]           mem_rdata_i;

  modport slave (
    input  req_valid_i, req_addr_i, req_we_i, req_size_i, req_unsigned_i, req_wdata_i,
    input  resp_ready_i, mem_rdata_i,
    output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
    output mem_addr_o, mem_wr_o, mem_wdata_o
  );

  modport master (
    output req_valid_i, req_addr_i, req_we_i, req_size_i, req_unsigned_i, req_wdata_i,
    output resp_ready_i, mem_rdata_i,
    input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
    input  mem_addr_o, mem_wr_o, mem_wdata_o
  );
endinterface

// File: rtl/tcm_lsu_port.sv
// Single-outstanding LSU-to-TCM port: byte-lane steering, registered-read capture, load extension.
// Define TCM_LSU_RANGE_CHECK_EN to flag addresses with non-zero bits above ADDR_WIDTH.
module tcm_lsu_port #(
  parameter int unsigned ADDR_WIDTH = 16
) (
  input logic            clk_i,
  input logic            rst_i,
  tcm_lsu_port_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StLive, StHold} state_e;

  state_e      r_state, w_state_d;
  logic [1:0]  r_off;
  logic [1:0]  r_size;
  logic        r_uns;
  logic        r_we;
  logic        r_err;
  logic [31:0] r_hold;

  logic        w_req_ready;
  logic        w_accept;
  logic        w_err;
  logic        w_range_err;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_raw;
  logic [31:0] w_sh;
  logic [31:0] w_fmt;

  assign w_req_ready = !rst_i && (r_state == StIdle || bus.resp_ready_i);
  assign w_accept    = bus.req_valid_i && w_req_ready;

`ifdef TCM_LSU_RANGE_CHECK_EN
  assign w_range_err = |bus.req_addr_i[31:ADDR_WIDTH];
`else
  assign w_range_err = 1'b0;
`endif

  assign w_err = (bus.req_size_i == 2'd3) ||
                 (bus.req_size_i == 2'd1 && bus.req_addr_i[0]) ||
                 (bus.req_size_i == 2'd2 && bus.req_addr_i[1:0] != 2'b00) ||
                 w_range_err;

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = bus.req_wdata_i;
    case (bus.req_size_i)
      2'd0: begin
        w_be    = 4'b0001 << bus.req_addr_i[1:0];
        w_wdata = {4{bus.req_wdata_i[7:0]}};
      end
      2'd1: begin
        w_be    = 4'b0011 << bus.req_addr_i[1:0];
        w_wdata = {2{bus.req_wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  // TCM port is idle (all zero) unless a request is being accepted this cycle.
  assign bus.mem_addr_o  = w_accept ? {2'b00, bus.req_addr_i[ADDR_WIDTH-1:2]} : '0;
  assign bus.mem_wr_o    = (w_accept && bus.req_we_i && !w_err) ? w_be : 4'b0000;
  assign bus.mem_wdata_o = w_accept ? w_wdata : 32'h0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  w_state_d = w_accept ? StLive : StIdle;
      StLive,
      StHold: begin
        if (bus.resp_ready_i) begin
          w_state_d = w_accept ? StLive : StIdle;
        end else begin
          w_state_d = StHold;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.req_ready_o  = w_req_ready;
    bus.resp_valid_o = (r_state != StIdle);
    bus.resp_err_o   = (r_state != StIdle) && r_err;
    bus.resp_rdata_o = (r_state != StIdle && !r_we && !r_err) ? w_fmt : 32'h0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_off  <= 2'd0;
      r_size <= 2'd0;
      r_uns  <= 1'b0;
      r_we   <= 1'b0;
      r_err  <= 1'b0;
      r_hold <= 32'h0;
    end else begin
      if (w_accept) begin
        r_off  <= bus.req_addr_i[1:0];
        r_size <= bus.req_size_i;
        r_uns  <= bus.req_unsigned_i;
        r_we   <= bus.req_we_i;
        r_err  <= w_err;
      end
      // Read data is only valid in the LIVE cycle, so keep a copy for stalls.
      if (r_state == StLive) begin
        r_hold <= bus.mem_rdata_i;
      end
    end
  end

  assign w_raw = (r_state == StLive) ? bus.mem_rdata_i : r_hold;
  assign w_sh  = w_raw >> {r_off, 3'b000};

  always_comb begin
    w_fmt = w_sh;
    case (r_size)
      2'd0:    w_fmt = r_uns ? {24'h0, w_sh[7:0]} : {{24{w_sh[7]}}, w_sh[7:0]};
      2'd1:    w_fmt = r_uns ? {16'h0, w_sh[15:0]} : {{16{w_sh[15]}}, w_sh[15:0]};
      default: w_fmt = w_sh;
    endcase
  end

endmodule

// File: tb/tb_tcm_lsu_port.sv
// Randomized bench for tcm_lsu_port against a byte-addressed reference memory.
module tb_tcm_lsu_port;
  localparam int unsigned AW    = 16;
  localparam int unsigned WORDS = 1 << (AW - 2);
  localparam int unsigned BYTES = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tcm_lsu_port_if #(.ADDR_WIDTH(AW)) bus ();

  tcm_lsu_port #(.ADDR_WIDTH(AW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // Behavioural TCM with registered read.
  logic [31:0] tcm [WORDS];
  always @(posedge clk) begin
    for (int l = 0; l < 4; l++) begin
      if (bus.mem_wr_o[l]) tcm[bus.mem_addr_o[AW-3:0]][8*l +: 8] <= bus.mem_wdata_o[8*l +: 8];
    end
    bus.mem_rdata_i <= tcm[bus.mem_addr_o[AW-3:0]];
  end

  // Reference model: flat byte memory plus the single pending response.
  logic [7:0]  ref_mem [BYTES];
  bit          m_pend;
  logic [31:0] m_rdata;
  bit          m_err;

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic do_cycle(input bit r, input bit v, input bit we, input bit [1:0] sz,
                          input bit uns, input bit [31:0] addr, input bit [31:0] wd,
                          input bit rr);
    int unsigned a, n;
    bit          e, acc, exp_rdy;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd, val;
    @(negedge clk);
    check_eq("resp_valid", {31'h0, bus.resp_valid_o}, {31'h0, m_pend});
    check_eq("resp_err", {31'h0, bus.resp_err_o}, m_pend ? {31'h0, m_err} : 32'h0);
    check_eq("resp_rdata", bus.resp_rdata_o, m_pend ? m_rdata : 32'h0);
    rst                = r;
    bus.req_valid_i    = v;
    bus.req_we_i       = we;
    bus.req_size_i     = sz;
    bus.req_unsigned_i = uns;
    bus.req_addr_i     = addr;
    bus.req_wdata_i    = wd;
    bus.resp_ready_i   = rr;
    #1;
    exp_rdy = !r && (!m_pend || rr);
    check_eq("req_ready", {31'h0, bus.req_ready_o}, {31'h0, exp_rdy});
    acc = v && exp_rdy;
    a   = addr % BYTES;
    n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    e   = (sz == 2'd3) || (a % n != 0);
`ifdef TCM_LSU_RANGE_CHECK_EN
    if (addr >= BYTES) e = 1'b1;
`endif
    exp_be = ((4'd1 << n) - 4'd1) << (a % 4);
    if (n == 4) exp_be = 4'hF;
    for (int l = 0; l < 4; l++) exp_wd[8*l +: 8] = wd[8*(l % n) +: 8];
    check_eq("mem_addr", {16'h0, bus.mem_addr_o}, acc ? a / 4 : 32'h0);
    check_eq("mem_wr", {28'h0, bus.mem_wr_o}, (acc && we && !e) ? {28'h0, exp_be} : 32'h0);
    check_eq("mem_wdata", bus.mem_wdata_o, acc ? exp_wd : 32'h0);
    if (acc) begin
      m_pend  = 1'b1;
      m_err   = e;
      m_rdata = 32'h0;
      if (!e && !we) begin
        val = 32'h0;
        for (int i = 0; i < int'(n); i++) val[8*i +: 8] = ref_mem[a + i];
        if (!uns && n < 4 && val[8*n-1]) val = val | ~((32'd1 << (8*n)) - 32'd1);
        m_rdata = val;
      end
      if (!e && we) for (int i = 0; i < int'(n); i++) ref_mem[a + i] = wd[8*i +: 8];
    end else if (r || rr) begin
      m_pend = 1'b0;
    end
  endtask

  task automatic idle(input bit rr);
    do_cycle(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, rr);
  endtask

  task automatic put_word(input int unsigned w, input logic [31:0] d);
    tcm[w] = d;
    for (int b = 0; b < 4; b++) ref_mem[4*w + b] = d[8*b +: 8];
  endtask

  initial begin
    bus.req_valid_i = 1'b0; bus.req_we_i = 1'b0; bus.req_size_i = 2'd0;
    bus.req_unsigned_i = 1'b0; bus.req_addr_i = 32'h0; bus.req_wdata_i = 32'h0;
    bus.resp_ready_i = 1'b0;
    m_pend = 1'b0; m_err = 1'b0; m_rdata = 32'h0;
    for (int w = 0; w < int'(WORDS); w++) put_word(w, $urandom);
    put_word(4, 32'h8899AABB);
    put_word(16, 32'hDEADBEEF);

    // Requests under reset must be refused and must not write.
    do_cycle(1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 32'h0, 32'h12345678, 1'b1);
    do_cycle(1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 32'h0, 32'h12345678, 1'b1);
    idle(1'b1);

    do_cycle(1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 1'b1);
    idle(1'b1);
    check_eq("half_signed", bus.resp_rdata_o, 32'hFFFF8899);
    do_cycle(1'b0, 1'b1, 1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 1'b1);
    idle(1'b1);
    check_eq("half_unsigned", bus.resp_rdata_o, 32'h00008899);

    do_cycle(1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 32'h21, 32'h5A, 1'b1);
    check_eq("sb_addr", {16'h0, bus.mem_addr_o}, 32'h8);
    check_eq("sb_wr", {28'h0, bus.mem_wr_o}, 32'h2);
    check_eq("sb_wdata", bus.mem_wdata_o, 32'h5A5A5A5A);
    do_cycle(1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 1'b1);

    do_cycle(1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 32'h6, 32'h0, 1'b1);
    do_cycle(1'b0, 1'b1, 1'b1, 2'd3, 1'b0, 32'h8, 32'hFFFFFFFF, 1'b1);
    check_eq("illegal_no_wr", {28'h0, bus.mem_wr_o}, 32'h0);
    idle(1'b1);

    // Stalled response must hold while new addresses are presented.
    do_cycle(1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      do_cycle(1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 32'h44 + 4 * i, 32'h0, 1'b0);
      check_eq("stall_rdata", bus.resp_rdata_o, 32'hDEADBEEF);
      check_eq("stall_ready", {31'h0, bus.req_ready_o}, 32'h0);
    end
    idle(1'b1);

    for (int i = 0; i < 3; i++) do_cycle(1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 4 * i, 32'h0, 1'b1);
    idle(1'b1);

    do_cycle(1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 1'b0);
    do_cycle(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 1'b0);
    idle(1'b0);
    check_eq("rst_drop", {31'h0, bus.resp_valid_o}, 32'h0);

    do_cycle(1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 32'h00010000, 32'hCAFEF00D, 1'b1);
`ifdef TCM_LSU_RANGE_CHECK_EN
    check_eq("range_wr", {28'h0, bus.mem_wr_o}, 32'h0);
`else
    check_eq("alias_wr", {28'h0, bus.mem_wr_o}, 32'hF);
    check_eq("alias_addr", {16'h0, bus.mem_addr_o}, 32'h0);
`endif
    idle(1'b1);

    for (int i = 0; i < 3000; i++) begin
      bit [31:0] addr;
      bit [1:0]  sz;
      addr = $urandom_range(0, 127);
      if ($urandom_range(0, 7) == 0) addr = addr | ($urandom & 32'hFFFF0000);
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      do_cycle($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
               sz, $urandom_range(0, 1) == 1, addr, $urandom, $urandom_range(0, 3) != 0);
    end
    idle(1'b1);
    idle(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
